// File: rtl/wr_arb_pkg.sv
// Shared write-path arbiter definitions: default widths and FSM state encoding.
package wr_arb_pkg;

    localparam int unsigned def_num_of_ports   = 16;
    localparam int unsigned def_priority_width = 3;
    localparam int unsigned def_port_idx_width = 4;
    localparam int unsigned def_max_hold       = 64;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        RELEASE = 2'd1,
        GRANT   = 2'd2
    } arb_state_e;

endpackage

// File: rtl/wr_port_arbiter_rr_max_pri_select.sv
// Combinational selector: highest priority among requesters, ties broken
// by scanning upward from rr_ptr with wrap-around.
module rr_max_pri_select
    import wr_arb_pkg::*;
#(
    parameter int unsigned num_of_ports   = def_num_of_ports,
    parameter int unsigned priority_width = def_priority_width,
    parameter int unsigned port_idx_width = def_port_idx_width
) (
    input  logic [num_of_ports-1:0]                req,
    input  logic [num_of_ports*priority_width-1:0] priority_in,
    input  logic [port_idx_width-1:0]              rr_ptr,
    output logic [num_of_ports-1:0]                winner,
    output logic [port_idx_width-1:0]              winner_idx
);

    localparam int unsigned idx_ext_width = port_idx_width + 1;

    logic [priority_width-1:0] max_pri;
    logic [num_of_ports-1:0]   cand;
    logic [idx_ext_width-1:0]  pos;
    logic                      found;

    // Max priority over requesters, candidate mask, then first candidate from rr_ptr.
    always_comb begin
        max_pri    = '0;
        cand       = '0;
        pos        = '0;
        found      = 1'b0;
        winner     = '0;
        winner_idx = '0;

        for (int i = 0; i < int'(num_of_ports); i++) begin
            if (req[i] && (priority_in[i*priority_width +: priority_width] > max_pri)) begin
                max_pri = priority_in[i*priority_width +: priority_width];
            end
        end

        for (int i = 0; i < int'(num_of_ports); i++) begin
            cand[i] = req[i] && (priority_in[i*priority_width +: priority_width] == max_pri);
        end

        for (int k = 0; k < int'(num_of_ports); k++) begin
            pos = idx_ext_width'(rr_ptr) + idx_ext_width'(k);
            if (pos >= idx_ext_width'(num_of_ports)) begin
                pos = pos - idx_ext_width'(num_of_ports);
            end
            if (!found && cand[port_idx_width'(pos)]) begin
                found                             = 1'b1;
                winner[port_idx_width'(pos)]      = 1'b1;
                winner_idx                        = port_idx_width'(pos);
            end
        end
    end

endmodule

// File: rtl/wr_port_arbiter.sv
// Shared SRAM write-path arbiter: priority + round-robin grant, held for a
// whole packet, released on last beat, requester abort or hold timeout.
module wr_port_arbiter
    import wr_arb_pkg::*;
#(
    parameter int unsigned num_of_ports   = def_num_of_ports,
    parameter int unsigned priority_width = def_priority_width,
    parameter int unsigned port_idx_width = def_port_idx_width,
    parameter int unsigned max_hold       = def_max_hold
) (
    input  logic                                   clk,
    input  logic                                   rst_n,
    input  logic [num_of_ports-1:0]                req,
    input  logic [num_of_ports*priority_width-1:0] priority_in,
    input  logic [num_of_ports-1:0]                last,
    input  logic                                   sram_ready,
    output logic [num_of_ports-1:0]                grant,
    output logic [port_idx_width-1:0]              grant_idx,
    output logic                                   grant_valid,
    output logic                                   timeout_err
);

    localparam int unsigned hold_cnt_width = $clog2(max_hold) + 1;

    arb_state_e                  state;
    arb_state_e                  state_d;
    logic [port_idx_width-1:0]   rr_ptr;
    logic [port_idx_width-1:0]   rr_ptr_d;
    logic [hold_cnt_width-1:0]   hold_cnt;
    logic [hold_cnt_width-1:0]   hold_cnt_d;
    logic [num_of_ports-1:0]     grant_d;
    logic [port_idx_width-1:0]   grant_idx_d;
    logic                        grant_valid_d;
    logic                        timeout_err_d;

    logic [num_of_ports-1:0]     sel_winner;
    logic [port_idx_width-1:0]   sel_idx;
    logic                        beat;

    rr_max_pri_select #(
        .num_of_ports   (num_of_ports),
        .priority_width (priority_width),
        .port_idx_width (port_idx_width)
    ) u_select (
        .req         (req),
        .priority_in (priority_in),
        .rr_ptr      (rr_ptr),
        .winner      (sel_winner),
        .winner_idx  (sel_idx)
    );

    // State and registered outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            grant       <= '0;
            grant_idx   <= '0;
            grant_valid <= 1'b0;
            timeout_err <= 1'b0;
            rr_ptr      <= '0;
            hold_cnt    <= '0;
        end else begin
            state       <= state_d;
            grant       <= grant_d;
            grant_idx   <= grant_idx_d;
            grant_valid <= grant_valid_d;
            timeout_err <= timeout_err_d;
            rr_ptr      <= rr_ptr_d;
            hold_cnt    <= hold_cnt_d;
        end
    end

    // Next-state and next-output logic; exit priority is last beat, abort, timeout.
    always_comb begin
        state_d       = state;
        grant_d       = grant;
        grant_idx_d   = grant_idx;
        grant_valid_d = grant_valid;
        timeout_err_d = 1'b0;
        rr_ptr_d      = rr_ptr;
        hold_cnt_d    = hold_cnt;
        beat          = sram_ready && req[grant_idx];

        case (state)
            IDLE: begin
                if (|req) begin
                    state_d       = GRANT;
                    grant_d       = sel_winner;
                    grant_idx_d   = sel_idx;
                    grant_valid_d = 1'b1;
                    hold_cnt_d    = '0;
                end
            end
            GRANT: begin
                if (hold_cnt != {hold_cnt_width{1'b1}}) begin
                    hold_cnt_d = hold_cnt + 1'b1;
                end
                if (beat && last[grant_idx]) begin
                    state_d       = RELEASE;
                    grant_d       = '0;
                    grant_valid_d = 1'b0;
                end else if (!req[grant_idx]) begin
                    state_d       = RELEASE;
                    grant_d       = '0;
                    grant_valid_d = 1'b0;
                end else if (hold_cnt == hold_cnt_width'(max_hold - 1)) begin
                    state_d       = RELEASE;
                    grant_d       = '0;
                    grant_valid_d = 1'b0;
                    timeout_err_d = 1'b1;
                end
            end
            RELEASE: begin
                state_d    = IDLE;
                hold_cnt_d = '0;
                if (grant_idx == port_idx_width'(num_of_ports - 1)) begin
                    rr_ptr_d = '0;
                end else begin
                    rr_ptr_d = grant_idx + 1'b1;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_wr_port_arbiter.sv
// Bench for wr_port_arbiter: directed scenarios plus random traffic, every
// cycle compared against a packet-level reference model.
module tb_wr_port_arbiter;

    localparam int N  = 16;
    localparam int PW = 3;

    logic          clk = 1'b0;
    logic          rst_n;
    logic [N-1:0]  req;
    logic [N*PW-1:0] pri;
    logic [N-1:0]  last;
    logic          sram_ready;
    logic [N-1:0]  grant;
    logic [3:0]    grant_idx;
    logic          grant_valid;
    logic          timeout_err;

    int errors = 0;
    int checks = 0;

    // Reference model state: who owns the path, release gap, hold age, rr start.
    int          m_owner;
    int          m_gap;
    int          m_hold;
    int          m_rr;
    int          m_next_rr;
    logic [N-1:0] e_grant;
    logic [3:0]  e_idx;
    logic        e_to;

    wr_port_arbiter dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .req         (req),
        .priority_in (pri),
        .last        (last),
        .sram_ready  (sram_ready),
        .grant       (grant),
        .grant_idx   (grant_idx),
        .grant_valid (grant_valid),
        .timeout_err (timeout_err)
    );

    always #5 clk = ~clk;

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        checks++;
        assert (obs === exp_v) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp_v);
        end
    endtask

    function automatic int get_pri(input int p);
        return int'(pri[p*PW +: PW]);
    endfunction

    task automatic set_pri(input int p, input int v);
        pri[p*PW +: PW] = 3'(v);
    endtask

    task automatic model_reset();
        m_owner   = -1;
        m_gap     = 0;
        m_hold    = 0;
        m_rr      = 0;
        m_next_rr = 0;
        e_grant   = '0;
        e_idx     = '0;
        e_to      = 1'b0;
    endtask

    // Predict outputs after the coming clock edge from the current inputs.
    task automatic model_step();
        bit done, abort, to;
        int best, w;
        e_to = 1'b0;
        if (m_owner >= 0) begin
            done  = sram_ready && req[m_owner] && last[m_owner];
            abort = !req[m_owner];
            to    = !done && !abort && (m_hold == 63);
            if (done || abort || to) begin
                m_next_rr = (m_owner + 1) % N;
                m_owner   = -1;
                m_gap     = 1;
                e_to      = to;
            end else begin
                m_hold++;
            end
        end else if (m_gap > 0) begin
            m_gap = 0;
            m_rr  = m_next_rr;
        end else if (req != '0) begin
            best = -1;
            w    = -1;
            for (int i = 0; i < N; i++)
                if (req[i] && get_pri(i) > best) best = get_pri(i);
            for (int k = 0; k < N; k++) begin
                int c;
                c = (m_rr + k) % N;
                if (w < 0 && req[c] && get_pri(c) == best) w = c;
            end
            m_owner = w;
            m_hold  = 0;
            e_idx   = 4'(w);
        end
        e_grant = (m_owner >= 0) ? (16'(1) << m_owner) : 16'h0;
    endtask

    task automatic check_all();
        check("grant", 32'(grant), 32'(e_grant));
        check("grant_valid", 32'(grant_valid), 32'(e_grant != '0));
        check("grant_idx", 32'(grant_idx), 32'(e_idx));
        check("timeout_err", 32'(timeout_err), 32'(e_to));
        check("rr_ptr", 32'(dut.rr_ptr), 32'(m_rr));
    endtask

    task automatic step();
        model_step();
        @(posedge clk);
        #1;
        check_all();
    endtask

    // Assert reset away from the clock edge, check, then release.
    task automatic do_reset();
        rst_n = 1'b0;
        #1;
        model_reset();
        check_all();
        #2;
        rst_n = 1'b1;
    endtask

    initial begin
        int held;
        int order [4];
        logic [N-1:0] exp_g;
        order = '{0, 4, 12, 0};

        rst_n = 1'b0;
        req = '0; last = '0; pri = '0; sram_ready = 1'b0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        check_all();
        check("reset_hold_cnt", 32'(dut.hold_cnt), 32'd0);
        rst_n = 1'b1;

        // Single requester, 4-beat packet.
        set_pri(5, 2); req = 16'h0020; sram_ready = 1'b1;
        step(); check("s1_grant", 32'(grant), 32'h20);
        step(); step(); step();
        check("s1_held", 32'(grant), 32'h20);
        last[5] = 1'b1;
        step(); check("s1_release", 32'(grant), 32'h0);
        req = '0; last = '0;
        step(); check("s1_rr", 32'(dut.rr_ptr), 32'd6);

        // Priority wins.
        do_reset();
        set_pri(1, 3); set_pri(9, 6); req = 16'h0202; sram_ready = 1'b1;
        step(); check("s2_first", 32'(grant), 32'h200);
        last = 16'h0200;
        step(); check("s2_release", 32'(grant), 32'h0);
        req[9] = 1'b0; last = '0;
        step();
        step(); check("s2_second", 32'(grant), 32'h2);
        last = 16'h0002;
        step(); req = '0; last = '0;
        step(); step();

        // Round-robin among equal priorities with 1-beat packets.
        do_reset();
        set_pri(0, 5); set_pri(4, 5); set_pri(12, 5);
        req = 16'h1011; last = 16'hFFFF; sram_ready = 1'b1;
        for (int s = 1; s <= 10; s++) begin
            step();
            exp_g = (s % 3 == 1) ? (16'(1) << order[(s-1)/3]) : 16'h0;
            check("s3_rr_seq", 32'(grant), 32'(exp_g));
        end
        req = '0; last = '0;
        step(); step(); step();

        // Timeout with SRAM never ready.
        do_reset();
        set_pri(3, 1); req = 16'h0008; sram_ready = 1'b0;
        held = 0;
        for (int i = 0; i < 70; i++) begin
            step();
            if (grant == 16'h0008) held++;
            else break;
        end
        check("s4_hold_cycles", 32'(held), 32'd64);
        check("s4_timeout_pulse", 32'(timeout_err), 32'd1);
        req = '0;
        step();
        check("s4_timeout_clear", 32'(timeout_err), 32'd0);
        check("s4_rr", 32'(dut.rr_ptr), 32'd4);

        // Abort after 2 beats; pending equal-priority port follows.
        set_pri(7, 4); set_pri(2, 4); req = 16'h0084; sram_ready = 1'b1; last = '0;
        step(); check("s5_grant7", 32'(grant), 32'h80);
        step(); step(); check("s5_held", 32'(grant), 32'h80);
        req[7] = 1'b0;
        step();
        check("s5_abort_release", 32'(grant), 32'h0);
        check("s5_no_timeout", 32'(timeout_err), 32'd0);
        step(); step(); check("s5_grant2", 32'(grant), 32'h4);
        last[2] = 1'b1;
        step(); req = '0; last = '0;
        step(); step();

        // Asynchronous reset in the middle of a grant.
        set_pri(10, 1); req = 16'h0400; sram_ready = 1'b0;
        step(); check("s6_grant", 32'(grant), 32'h400);
        step();
        rst_n = 1'b0;
        #1;
        model_reset();
        check("s6_async_grant", 32'(grant), 32'h0);
        check("s6_async_valid", 32'(grant_valid), 32'd0);
        check("s6_async_rr", 32'(dut.rr_ptr), 32'd0);
        check("s6_async_timeout", 32'(timeout_err), 32'd0);
        #2;
        rst_n = 1'b1;
        step(); check("s6_regrant", 32'(grant), 32'h400);
        sram_ready = 1'b1; last = 16'h0400;
        step(); req = '0; last = '0;
        step(); step();

        // Random traffic, with periodic low-ready windows to provoke timeouts.
        for (int c = 0; c < 4000; c++) begin
            sram_ready = ($urandom_range(99) < (((c % 600) < 120) ? 3 : 75));
            for (int i = 0; i < N; i++) begin
                if (req[i]) begin
                    if ($urandom_range(99) < 1) req[i] = 1'b0;
                end else if ($urandom_range(99) < 10) begin
                    req[i] = 1'b1;
                    set_pri(i, int'($urandom_range(7)));
                end
                last[i] = ($urandom_range(99) < 25);
            end
            step();
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/wr_port_arbiter.md
# wr_port_arbiter

Grants exclusive access to the shared SRAM write path to one of `num_of_ports` ingress ports at a time. Per-port priorities come from the write-path priority decoder: 3-bit field, 7 is highest. Highest priority wins; ties among equal-priority requesters are broken round-robin. The grant is held for a whole packet (until `last`), or until a transfer timeout or requester abort. The block sits between the ingress port buffers and the SRAM write datapath mux.

## Interface
- `num_of_ports`, 16, number of requesting ports
- `priority_width`, 3, priority field width per port
- `port_idx_width`, 4, width of the encoded port index (clog2 of `num_of_ports`)
- `max_hold`, 64, maximum cycles a grant may be held before forced release
- Clock and reset: one clock; reset is asynchronous and active-low.
- `clk`  input  1  clock
- `rst_n`  input  1  asynchronous active-low reset
- `req`  input  num_of_ports  per-port write request, level, held until the packet ends
- `priority_in`  input  num_of_ports*priority_width  per-port priority; port i occupies bits [i*priority_width +: priority_width]
- `last`  input  num_of_ports  per-port end-of-packet flag; only the granted port's bit is used
- `sram_ready`  input  1  SRAM write path accepts a beat this cycle
- `grant`  output  num_of_ports  one-hot grant, registered
- `grant_idx`  output  port_idx_width  encoded index of the granted port
- `grant_valid`  output  1  a grant is active
- `timeout_err`  output  1  one-cycle pulse on a forced release caused by timeout

## Operation
- FSM states: IDLE, GRANT, RELEASE.
- **IDLE**
  - If `|req`, arbitrate and go to GRANT. The winner is registered into `grant`/`grant_idx`.
  - Otherwise stay in IDLE.
- **Arbitration** (combinational, evaluated in IDLE only)
  - Find `max_pri`, the maximum of `priority_in` over ports with `req` set.
  - Candidates are the requesting ports with priority equal to `max_pri`.
  - The winner is the first candidate found scanning upward from `rr_ptr`, wrapping modulo `num_of_ports`.
- **Beats**
  - A beat is a cycle in GRANT with `sram_ready && req[grant_idx]`.
  - The hold counter `hold_cnt` increments every cycle spent in GRANT, whether or not a beat occurs.
- **GRANT exit conditions**, checked in this order:
  - A beat with `last[grant_idx]` goes to RELEASE. This is normal completion.
  - `req[grant_idx]` low goes to RELEASE. This is an abort; there is no error flag.
  - `hold_cnt == max_hold-1` with no completion that cycle goes to RELEASE and pulses `timeout_err`.
- **RELEASE**
  - `grant` is 0 and `grant_valid` is 0.
  - `rr_ptr` is set to `grant_idx+1`, wrapping to 0 after `num_of_ports-1`.
  - `hold_cnt` is cleared.
  - Always go to IDLE.
- `rr_ptr` updates only in RELEASE. A timeout or abort still advances it, so a stalled port cannot win the next tie.
- The `req`, `last` and `priority_in` bits of non-granted ports are ignored during GRANT.
- `hold_cnt` width is clog2(`max_hold`)+1. It saturates and never wraps.

## Timing
- Reset values, all asynchronous: `grant`=0, `grant_idx`=0, `grant_valid`=0, `timeout_err`=0, `rr_ptr`=0, `hold_cnt`=0, state=IDLE.
- Request to grant: `req` first high in IDLE at cycle N gives `grant`/`grant_valid` high at cycle N+1.
- `priority_in` is sampled in the same cycle as `req`. The decoder output is already registered, so its one-cycle lag is the requester's responsibility: hold `req` low until the priority is valid.
- Completing beat at cycle M:
  - `grant` drops at M+1 (RELEASE).
  - IDLE at M+2.
  - The earliest next grant is at M+3.
  - Minimum gap between packets: 2 idle grant cycles.
- `timeout_err` is high for exactly the one RELEASE cycle that follows a timeout exit.
- The single-beat packet case is legal: `last` on the first beat gives a 1-cycle grant.
- `grant` is always one-hot or zero, and `grant_valid == |grant`.
- Reset asserted mid-GRANT: outputs clear immediately (asynchronously) and no `timeout_err` is emitted.

## Structure
- A shared package `wr_arb_pkg` holds the state encoding enum (IDLE/RELEASE/GRANT) and the default widths. `priority_width` and `port_idx_width` defaults are shared with the priority decoder.
- One sub-module: `rr_max_pri_select`. It is the combinational max-priority plus round-robin selector: inputs `req`, `priority_in`, `rr_ptr`; outputs one-hot `winner` and its index. It is reusable by the read-side arbiter.
- The FSM, `hold_cnt`, `rr_ptr` and output registers live in `wr_port_arbiter`.

## Test plan
- Single requester: port 5 `req` at priority 2; 4 beats, `last` on beat 4 with `sram_ready`=1 throughout.
  - `grant`=0x0020 one cycle after `req`, held 4 cycles.
  - Then RELEASE; `rr_ptr`=6.
- Priority wins: ports 1 (pri 3) and 9 (pri 6) request together from reset.
  - Port 9 granted first.
  - Port 1 granted 3 cycles after port 9's last beat.
- Round-robin tie: ports 0, 4 and 12, all priority 5, each sending 1-beat packets and re-requesting continuously.
  - Grant order 0, 4, 12, 0.
  - Each grant is 1 cycle high followed by 2 idle cycles.
- Timeout: port 3 granted with `sram_ready`=0 forever, `max_hold`=64.
  - `grant` stays high 64 cycles.
  - Then RELEASE with `timeout_err`=1 for 1 cycle; `rr_ptr`=4.
- Abort: port 7 granted; `req[7]` drops after 2 beats.
  - RELEASE next cycle, `timeout_err`=0.
  - A pending port 2 (same priority) is granted 2 cycles later.
- Reset mid-transfer: `rst_n` pulled low during port 10's grant.
  - `grant`, `grant_valid` and `rr_ptr` read 0 before the next `clk` edge.
  - After release, a port 10 request is granted normally.
